// File: rtl/rv_isa_pkg.sv
// RV32I definitions shared by the instruction loader and the decoder:
// opcode constants, instruction format codes, loader state and error codes.
package rv_isa_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OPCODE   = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERROR
   } load_state_e;

   // FMT_NONE marks an opcode the loader refuses to write.
   function automatic fmt_e opcode_fmt(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_REG:                    f = FMT_R;
         OP_JALR, OP_LOAD, OP_IMM:  f = FMT_I;
         OP_STORE:                  f = FMT_S;
         OP_BRANCH:                 f = FMT_B;
         OP_LUI, OP_AUIPC:          f = FMT_U;
         OP_JAL:                    f = FMT_J;
         default:                   f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder: packs decoded record fields into an
// instruction word; fields a format does not use are left zero.
module instr_encoder
   import rv_isa_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        supported_o
);

   fmt_e fmt;
   logic shift_imm;

   assign fmt       = opcode_fmt(opcode_i);
   // Immediate shifts carry funct7 in the upper immediate bits.
   assign shift_imm = (opcode_i == OP_IMM) && ((funct3_i == 3'b001) || (funct3_i == 3'b101));

   always_comb begin
      word_o      = 32'h0;
      supported_o = 1'b1;
      case (fmt)
         FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: begin
            if (shift_imm) word_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            else           word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         end
         FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         default: supported_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a valid/ready record stream, encodes each
// record and writes the words to consecutive imem addresses from BASE_ADDR.
module imem_loader
   import rv_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   input  logic                  in_last,
   output logic                  imem_wr_en,
   output logic [ADDR_WIDTH-1:0] imem_wr_addr,
   output logic [31:0]           imem_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            err,
   output logic [ADDR_WIDTH:0]   count,
   output load_state_e           dbg_state
);

   // Handshake: a record transfers on a rising clk edge where in_valid and
   // in_ready are both high; in_ready depends on registered state only.

   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   FINAL_IDX = CAPACITY - CNT_ONE;

   load_state_e           state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]           wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic [1:0]            err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_supported;
   logic        ready;
   logic        accept;

   instr_encoder u_encoder (
      .opcode_i    (in_opcode),
      .rd_i        (in_rd),
      .rs1_i       (in_rs1),
      .rs2_i       (in_rs2),
      .funct3_i    (in_funct3),
      .funct7_i    (in_funct7),
      .imm_i       (in_imm),
      .word_o      (enc_word),
      .supported_o (enc_supported)
   );

   assign ready  = (state_q == ST_LOAD) && (count_q != CAPACITY);
   assign accept = in_valid && ready;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      err_d     = err_q;
      if (state_q != ST_LOAD) begin
         if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            ptr_d   = BASE;
            done_d  = 1'b0;
            err_d   = ERR_NONE;
         end
      end else if (accept) begin
         if (!enc_supported) begin
            err_d   = ERR_OPCODE;
            state_d = ST_ERROR;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = enc_word;
            ptr_d     = ptr_q + PTR_ONE;
            count_d   = count_q + CNT_ONE;
            // A last record that also fills memory is a clean finish.
            if (in_last) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (count_q == FINAL_IDX) begin
               err_d   = ERR_OVERFLOW;
               state_d = ST_ERROR;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         ptr_q     <= BASE;
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE;
         wr_data_q <= 32'h0;
         done_q    <= 1'b0;
         err_q     <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign in_ready     = ready;
   assign imem_wr_en   = wr_en_q;
   assign imem_wr_addr = wr_addr_q;
   assign imem_wr_data = wr_data_q;
   assign busy         = (state_q == ST_LOAD);
   assign done         = done_q;
   assign err          = err_q;
   assign count        = count_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default instance (8-bit address, base 0) and a
// small wrapping instance (2-bit address, base 3) driven from shared fields.
module tb_imem_loader;
   import rv_isa_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        in_last = 1'b0;

   logic        start0, valid0, rdy0, wr_en0, busy0, done0;
   logic [7:0]  addr0;
   logic [31:0] data0;
   logic [1:0]  err0;
   logic [8:0]  count0;
   load_state_e st0;

   logic        start1, valid1, rdy1, wr_en1, busy1, done1;
   logic [1:0]  addr1;
   logic [31:0] data1;
   logic [1:0]  err1;
   logic [2:0]  count1;
   load_state_e st1;

   assign start0 = start & ~sel;
   assign valid0 = in_valid & ~sel;
   assign start1 = start & sel;
   assign valid1 = in_valid & sel;

   imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .in_valid(valid0), .in_ready(rdy0),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .imem_wr_en(wr_en0), .imem_wr_addr(addr0), .imem_wr_data(data0),
      .busy(busy0), .done(done0), .err(err0), .count(count0), .dbg_state(st0)
   );

   imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(valid1), .in_ready(rdy1),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .imem_wr_en(wr_en1), .imem_wr_addr(addr1), .imem_wr_data(data1),
      .busy(busy1), .done(done1), .err(err1), .count(count1), .dbg_state(st1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Expected writes: {addr[7:0], data[31:0]}.
   logic [39:0] exp_q0[$];
   logic [39:0] exp_q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en0) begin
         if (exp_q0.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut0 unexpected write: addr %h data %h at %0t", addr0, data0, $time);
         end else begin
            logic [39:0] e;
            e = exp_q0.pop_front();
            check("dut0 wr_addr", {24'h0, addr0}, {24'h0, e[39:32]});
            check("dut0 wr_data", data0, e[31:0]);
         end
      end
      if (wr_en1) begin
         if (exp_q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut1 unexpected write: addr %h data %h at %0t", addr1, data1, $time);
         end else begin
            logic [39:0] e;
            e = exp_q1.pop_front();
            check("dut1 wr_addr", {30'h0, addr1}, {24'h0, e[39:32]});
            check("dut1 wr_data", data1, e[31:0]);
         end
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic last, output int waited);
      logic acc;
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      acc = 1'b0;
      waited = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = sel ? rdy1 : rdy0;
         @(posedge clk); #1;
         waited++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL send timeout: record not accepted within 20 cycles at %0t", $time);
      end
   endtask

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int w;
      vecs[0] = '{7'b0010011, 5'd1, 5'd0, 5'd0,  3'b000, 7'h00, 32'd5,        32'h00500093}; // addi x1,x0,5
      vecs[1] = '{7'b1101111, 5'd1, 5'd0, 5'd0,  3'b000, 7'h00, 32'd16,       32'h010000EF}; // jal x1,+16
      vecs[2] = '{7'b0010011, 5'd3, 5'd3, 5'd0,  3'b101, 7'h20, 32'd4,        32'h4041D193}; // srai x3,x3,4
      vecs[3] = '{7'b0010011, 5'd1, 5'd0, 5'd31, 3'b000, 7'h7F, 32'd5,        32'h00500093}; // addi, stray rs2/f7
      vecs[4] = '{7'b0010011, 5'd1, 5'd1, 5'd0,  3'b001, 7'h00, 32'hFFFFFFFF, 32'h01F09093}; // slli x1,x1,31
      vecs[5] = '{7'b1100111, 5'd1, 5'd2, 5'd0,  3'b000, 7'h00, 32'hFFFFFFFC, 32'hFFC100E7}; // jalr x1,-4(x2)
      vecs[6] = '{7'b0000011, 5'd5, 5'd6, 5'd0,  3'b010, 7'h00, 32'd16,       32'h01032283}; // lw x5,16(x6)
      vecs[7] = '{7'b0010111, 5'd7, 5'd0, 5'd0,  3'b000, 7'h00, 32'hABCDE000, 32'hABCDE397}; // auipc x7
      vecs[8] = '{7'b1100011, 5'd0, 5'd1, 5'd2,  3'b001, 7'h00, 32'hFFFFFFF8, 32'hFE209CE3}; // bne x1,x2,-8
      vecs[9] = '{7'b0110011, 5'd3, 5'd1, 5'd2,  3'b000, 7'h20, 32'd0,        32'h402081B3}; // sub x3,x1,x2

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, both instances.
      check("rst in_ready0", {31'h0, rdy0}, 32'h0);
      check("rst wr_en0", {31'h0, wr_en0}, 32'h0);
      check("rst wr_addr0", {24'h0, addr0}, 32'h0);
      check("rst wr_data0", data0, 32'h0);
      check("rst busy0", {31'h0, busy0}, 32'h0);
      check("rst done0", {31'h0, done0}, 32'h0);
      check("rst err0", {30'h0, err0}, 32'h0);
      check("rst count0", {23'h0, count0}, 32'h0);
      check("rst state0", {30'h0, st0}, {30'h0, ST_IDLE});
      check("rst wr_addr1", {30'h0, addr1}, 32'h3);
      check("rst in_ready1", {31'h0, rdy1}, 32'h0);

      // Single-record programs from the vector table.
      for (int i = 0; i < 10; i++) begin
         pulse_start();
         check("start busy", {31'h0, busy0}, 32'h1);
         check("start in_ready", {31'h0, rdy0}, 32'h1);
         exp_q0.push_back({8'h00, vecs[i].exp_word});
         send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7,
              vecs[i].imm, 1'b1, w);
         check("vec done", {31'h0, done0}, 32'h1);
         check("vec in_ready", {31'h0, rdy0}, 32'h0);
         check("vec count", {23'h0, count0}, 32'h1);
         check("vec state", {30'h0, st0}, {30'h0, ST_DONE});
         @(posedge clk); #1;
      end

      // Back-to-back lui / sw / beq; lui low immediate bits must be dropped.
      pulse_start();
      exp_q0.push_back({8'd0, 32'h12345137});
      exp_q0.push_back({8'd1, 32'h00112423});
      exp_q0.push_back({8'd2, 32'h00208463});
      send(7'b0110111, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345FFF, 1'b0, w);
      check("b2b wait lui", w, 32'd1);
      check("b2b count1", {23'h0, count0}, 32'h1);
      send(7'b0100011, 5'd0, 5'd2, 5'd1, 3'b010, 7'h00, 32'd8, 1'b0, w);
      check("b2b wait sw", w, 32'd1);
      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd8, 1'b1, w);
      check("b2b wait beq", w, 32'd1);
      check("b2b count3", {23'h0, count0}, 32'h3);
      check("b2b done", {31'h0, done0}, 32'h1);
      @(posedge clk); #1;

      // Start during LOAD is ignored: address keeps counting.
      pulse_start();
      exp_q0.push_back({8'd0, 32'h00500093});
      exp_q0.push_back({8'd1, 32'h00500093});
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0, w);
      pulse_start();
      check("restart ignored count", {23'h0, count0}, 32'h1);
      check("restart ignored busy", {31'h0, busy0}, 32'h1);
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b1, w);
      check("restart ignored count2", {23'h0, count0}, 32'h2);

      // Unsupported opcode: no write, err 01, then recovery via start.
      pulse_start();
      send(7'b0000000, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0, 1'b0, w);
      check("badop err", {30'h0, err0}, {30'h0, ERR_OPCODE});
      check("badop in_ready", {31'h0, rdy0}, 32'h0);
      check("badop wr_en", {31'h0, wr_en0}, 32'h0);
      check("badop count", {23'h0, count0}, 32'h0);
      check("badop state", {30'h0, st0}, {30'h0, ST_ERROR});
      repeat (2) @(posedge clk); #1;
      check("badop err sticky", {30'h0, err0}, {30'h0, ERR_OPCODE});
      pulse_start();
      check("recover err", {30'h0, err0}, 32'h0);
      check("recover busy", {31'h0, busy0}, 32'h1);
      exp_q0.push_back({8'd0, 32'h010000EF});
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd16, 1'b1, w);
      check("recover done", {31'h0, done0}, 32'h1);

      // Reset the cycle after an accept.
      pulse_start();
      exp_q0.push_back({8'd0, 32'h00500093});
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0, w);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst wr_en", {31'h0, wr_en0}, 32'h0);
      check("midrst state", {30'h0, st0}, {30'h0, ST_IDLE});
      check("midrst in_ready", {31'h0, rdy0}, 32'h0);
      check("midrst busy", {31'h0, busy0}, 32'h0);
      check("midrst count", {23'h0, count0}, 32'h0);
      check("midrst wr_addr", {24'h0, addr0}, 32'h0);
      check("midrst wr_data", data0, 32'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("midrst idle", {30'h0, st0}, {30'h0, ST_IDLE});

      // Overflow on the small instance: addresses wrap from base 3.
      sel = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a;
         a = 8'((3 + i) % 4);
         exp_q1.push_back({a, 32'h00000093 | (32'(i + 1) << 20)});
         send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'(i + 1), 1'b0, w);
         if (i == 2) check("ovf err before", {30'h0, err1}, 32'h0);
      end
      check("ovf err", {30'h0, err1}, {30'h0, ERR_OVERFLOW});
      check("ovf in_ready", {31'h0, rdy1}, 32'h0);
      check("ovf count", {29'h0, count1}, 32'h4);
      check("ovf done", {31'h0, done1}, 32'h0);
      check("ovf state", {30'h0, st1}, {30'h0, ST_ERROR});
      sel = 1'b0;

      repeat (4) @(posedge clk); #1;
      check("dut0 queue drained", exp_q0.size(), 32'h0);
      check("dut1 queue drained", exp_q1.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
